// File: rtl/nios2_debug_jtag_pkg.sv
// Shared types and constants for the Nios II debug-slave virtual-JTAG host driver.
package nios2_debug_jtag_pkg;

   // Virtual JTAG walk: one full scan visits every state once, in this order.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_UIR  = 3'd1,
      ST_CDR  = 3'd2,
      ST_SDR  = 3'd3,
      ST_UDR  = 3'd4,
      ST_RTI  = 3'd5
   } jtag_state_t;

   // Debug-slave virtual IR codes.
   localparam logic [1:0] IR_MONITOR   = 2'b00;
   localparam logic [1:0] IR_BREAK     = 2'b01;
   localparam logic [1:0] IR_TRACEMEM  = 2'b10;
   localparam logic [1:0] IR_TRACECTRL = 2'b11;

   // Length of the debug slave sr/jdo scan chain.
   localparam int DEFAULT_DR_WIDTH = 38;

endpackage

// File: rtl/nios2_debug_tck_gen.sv
// TCK divider: toggles the test clock every TCK_HALF clk cycles while enabled and
// reports the toggle direction as single-clk rise/fall strobes.
// The first half-period after enabling is held low, so the first rising edge lands
// one full TCK period after the scan starts and every state spans a whole period.
module nios2_debug_tck_gen #(
   parameter int TCK_HALF = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   input  logic i_clear,
   output logic o_tck,
   output logic o_tck_rise,
   output logic o_tck_fall
);

   localparam int CW = $clog2(TCK_HALF);

   logic [CW-1:0] r_div;
   logic          r_tck;
   logic          r_armed;
   logic          w_term;

   assign w_term     = i_en && (r_div == CW'(TCK_HALF - 1));
   assign o_tck_rise = w_term && r_armed && !r_tck;
   assign o_tck_fall = w_term && r_armed && r_tck;
   assign o_tck      = r_tck;

   // Half-period counter and TCK toggle; disabled or cleared parks TCK low.
   always_ff @(posedge clk) begin
      if (reset || !i_en || i_clear) begin
         r_div   <= '0;
         r_tck   <= 1'b0;
         r_armed <= 1'b0;
      end else if (w_term) begin
         r_div   <= '0;
         r_armed <= 1'b1;
         if (r_armed) begin
            r_tck <= !r_tck;
         end
      end else begin
         r_div <= r_div + CW'(1);
      end
   end

endmodule

// File: rtl/nios2_debug_slave_jtag_host.sv
// Host-side virtual-JTAG driver for the Nios II debug slave. Takes one {IR, DR}
// command, walks UIR->CDR->SDR->UDR->RTI on a generated TCK and returns the
// captured DR and ir_out as a one-clk response.
module nios2_debug_slave_jtag_host
   import nios2_debug_jtag_pkg::*;
#(
   parameter int IR_WIDTH    = 2,
   parameter int DR_WIDTH    = DEFAULT_DR_WIDTH,
   parameter int TCK_HALF    = 4,
   parameter int RTI_PERIODS = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [IR_WIDTH-1:0] cmd_ir,
   input  logic [DR_WIDTH-1:0] cmd_dr,
   output logic                rsp_valid,
   output logic [DR_WIDTH-1:0] rsp_dr,
   output logic [IR_WIDTH-1:0] rsp_ir_out,
   output logic                vji_tck,
   output logic                vji_tdi,
   input  logic                vji_tdo,
   output logic [IR_WIDTH-1:0] vji_ir_in,
   input  logic [IR_WIDTH-1:0] vji_ir_out,
   output logic                vji_uir,
   output logic                vji_cdr,
   output logic                vji_sdr,
   output logic                vji_udr,
   output logic                vji_rti
);

   localparam int BW = $clog2(DR_WIDTH + 1);
   localparam int RW = $clog2(RTI_PERIODS + 1);

   jtag_state_t         r_state;
   jtag_state_t         w_state_next;
   logic [DR_WIDTH-1:0] r_shift;
   logic [BW-1:0]       r_bit_cnt;
   logic [RW-1:0]       r_rti_cnt;
   logic [IR_WIDTH-1:0] r_ir_in;
   logic [IR_WIDTH-1:0] r_ir_cap;
   logic                r_tdi;
   logic                r_rsp_valid;
   logic [DR_WIDTH-1:0] r_rsp_dr;
   logic [IR_WIDTH-1:0] r_rsp_ir_out;
   logic                w_tck_rise;
   logic                w_tck_fall;
   logic                w_last_bit;
   logic                w_last_rti;
   logic                w_scan_done;

   assign w_last_bit  = (r_bit_cnt == BW'(DR_WIDTH - 1));
   assign w_last_rti  = (r_rti_cnt == RW'(RTI_PERIODS - 1));
   assign w_scan_done = w_tck_rise && (r_state == ST_RTI) && w_last_rti;

   // The closing RTI edge clears the divider so TCK is already low when IDLE is entered.
   nios2_debug_tck_gen #(
      .TCK_HALF (TCK_HALF)
   ) u_tck_gen (
      .clk        (clk),
      .reset      (reset),
      .i_en       (r_state != ST_IDLE),
      .i_clear    (w_scan_done),
      .o_tck      (vji_tck),
      .o_tck_rise (w_tck_rise),
      .o_tck_fall (w_tck_fall)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state: accept from IDLE, everything else advances on a TCK rising edge.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (cmd_valid)                 w_state_next = ST_UIR;
         ST_UIR:  if (w_tck_rise)                w_state_next = ST_CDR;
         ST_CDR:  if (w_tck_rise)                w_state_next = ST_SDR;
         ST_SDR:  if (w_tck_rise && w_last_bit)  w_state_next = ST_UDR;
         ST_UDR:  if (w_tck_rise)                w_state_next = ST_RTI;
         ST_RTI:  if (w_scan_done)               w_state_next = ST_IDLE;
         default:                                w_state_next = ST_IDLE;
      endcase
   end

   // State indicators and handshake ready, decoded from the current state.
   always_comb begin
      cmd_ready = 1'b0;
      vji_uir   = 1'b0;
      vji_cdr   = 1'b0;
      vji_sdr   = 1'b0;
      vji_udr   = 1'b0;
      vji_rti   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            vji_rti   = 1'b1;
         end
         ST_UIR:  vji_uir = 1'b1;
         ST_CDR:  vji_cdr = 1'b1;
         ST_SDR:  vji_sdr = 1'b1;
         ST_UDR:  vji_udr = 1'b1;
         ST_RTI:  vji_rti = 1'b1;
         default: ;
      endcase
   end

   // Command latch, TDI launch on falling TCK, TDO capture on rising TCK, response.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_shift      <= '0;
         r_bit_cnt    <= '0;
         r_rti_cnt    <= '0;
         r_ir_in      <= '0;
         r_ir_cap     <= '0;
         r_tdi        <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_rsp_dr     <= '0;
         r_rsp_ir_out <= '0;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  r_ir_in   <= cmd_ir;
                  r_shift   <= cmd_dr;
                  r_bit_cnt <= '0;
                  r_rti_cnt <= '0;
               end
            end
            ST_CDR: begin
               if (w_tck_fall) r_tdi    <= r_shift[0];
               if (w_tck_rise) r_ir_cap <= vji_ir_out;
            end
            ST_SDR: begin
               if (w_tck_fall) r_tdi <= r_shift[0];
               if (w_tck_rise) begin
                  r_shift <= {vji_tdo, r_shift[DR_WIDTH-1:1]};
                  if (!w_last_bit) r_bit_cnt <= r_bit_cnt + BW'(1);
               end
            end
            ST_RTI: begin
               if (w_scan_done) begin
                  r_rsp_valid  <= 1'b1;
                  r_rsp_dr     <= r_shift;
                  r_rsp_ir_out <= r_ir_cap;
               end else if (w_tck_rise) begin
                  r_rti_cnt <= r_rti_cnt + RW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign vji_tdi    = r_tdi;
   assign vji_ir_in  = r_ir_in;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_dr     = r_rsp_dr;
   assign rsp_ir_out = r_rsp_ir_out;

endmodule

// File: tb/tb_nios2_debug_slave_jtag_host.sv
// Bench for the virtual-JTAG host: a time-based model of the scan (state from elapsed
// clk count, expected DR from the TDO bits the bench itself presents) is compared
// against the DUT every cycle, plus literal checks on a known loopback scan.
module tb_nios2_debug_slave_jtag_host;
   import nios2_debug_jtag_pkg::*;

   localparam int IRW   = 2;
   localparam int DRW   = 38;
   localparam int TH    = 4;
   localparam int RTIP  = 8;
   localparam int PER   = 2 * TH;
   localparam int NRISE = 3 + DRW + RTIP;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           cmd_valid = 1'b0;
   logic           cmd_ready;
   logic [IRW-1:0] cmd_ir = '0;
   logic [DRW-1:0] cmd_dr = '0;
   logic           rsp_valid;
   logic [DRW-1:0] rsp_dr;
   logic [IRW-1:0] rsp_ir_out;
   logic           vji_tck, vji_tdi;
   logic           vji_tdo = 1'b0;
   logic [IRW-1:0] vji_ir_in, vji_ir_out;
   logic           vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

   logic [1:0]     cdr_val = 2'b10;
   bit             loopback = 1'b0;

   assign vji_ir_out = vji_cdr ? cdr_val : ~cdr_val;

   always #5 clk = ~clk;

   nios2_debug_slave_jtag_host #(
      .IR_WIDTH(IRW), .DR_WIDTH(DRW), .TCK_HALF(TH), .RTI_PERIODS(RTIP)
   ) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
      .rsp_valid(rsp_valid), .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out),
      .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
      .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
      .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti)
   );

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- model state (written only by the monitor) ----------------
   bit             m_valid = 0, m_busy = 0, m_rsp = 0, post_reset = 0, tdo_pend = 0;
   int             m_k = 0, m_lat = 0, m_rises = 0;
   int             n_acc = 0, n_rsp = 0;
   logic [DRW-1:0] m_cmd_dr = '0, m_exp_dr = '0, m_rsp_dr_exp = '0;
   logic [IRW-1:0] m_ir_in = '0, m_ir_exp = '0, m_rsp_ir_exp = '0;
   logic           tdo_next = 1'b0;
   logic           prev_tck, prev_tdi, prev_ready, prev_sdr;
   int             ind_cyc [5];
   int             sdr_rises = 0;
   int             last_latency = 0, last_sdr_rises = 0;
   int             last_ind_cyc [5];
   logic [DRW-1:0] last_rsp_dr = '0;
   logic [IRW-1:0] last_rsp_ir = '0;

   // Per-cycle compare against the model, then advance the model past the next edge.
   always @(negedge clk) begin
      int n, r;
      logic [4:0] e_ind, a_ind;
      logic e_tck, e_ready, e_rv;
      if (tdo_pend) begin
         vji_tdo  = tdo_next;
         tdo_pend = 0;
      end
      if (m_busy || m_rsp) m_lat++;
      a_ind = {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti};
      if (m_valid) begin
         if (m_busy) begin
            n       = m_k / PER;
            e_ready = 1'b0;
            e_rv    = 1'b0;
            e_tck   = (m_k >= PER) && ((m_k / TH) % 2 == 0);
            if (n == 0)             e_ind = 5'b10000;
            else if (n == 1)        e_ind = 5'b01000;
            else if (n <= DRW + 1)  e_ind = 5'b00100;
            else if (n == DRW + 2)  e_ind = 5'b00010;
            else                    e_ind = 5'b00001;
         end else begin
            e_ready = 1'b1;
            e_rv    = m_rsp;
            e_tck   = 1'b0;
            e_ind   = 5'b00001;
         end
         check("cmd_ready", cmd_ready, e_ready);
         check("indicators", a_ind, e_ind);
         check("onehot", $countones(a_ind), 1);
         check("tck", vji_tck, e_tck);
         check("rsp_valid", rsp_valid, e_rv);
         check("ir_in", vji_ir_in, m_ir_in);
         if (e_rv) begin
            check("rsp_dr", rsp_dr, m_rsp_dr_exp);
            check("rsp_ir_out", rsp_ir_out, m_rsp_ir_exp);
         end
         if (post_reset) begin
            check("reset_tdi", vji_tdi, 0);
            check("reset_rsp_dr", rsp_dr, 0);
            check("reset_rsp_ir_out", rsp_ir_out, 0);
         end
         if (vji_tck === 1'b1 && prev_tck === 1'b0) begin
            check("tdi_stable_at_rise", vji_tdi, prev_tdi);
            if (prev_sdr === 1'b1) sdr_rises++;
         end
         if (cmd_ready === 1'b1 && prev_ready === 1'b0 && !post_reset)
            check("ready_rise_with_rsp", rsp_valid, 1);
         if (vji_uir) ind_cyc[0]++;
         if (vji_cdr) ind_cyc[1]++;
         if (vji_sdr) ind_cyc[2]++;
         if (vji_udr) ind_cyc[3]++;
         if (vji_rti && !cmd_ready) ind_cyc[4]++;
         if (rsp_valid === 1'b1) begin
            n_rsp++;
            last_latency   = m_lat;
            last_rsp_dr    = rsp_dr;
            last_rsp_ir    = rsp_ir_out;
            last_sdr_rises = sdr_rises;
            for (int i = 0; i < 5; i++) last_ind_cyc[i] = ind_cyc[i];
         end
      end
      prev_tck   = vji_tck;
      prev_tdi   = vji_tdi;
      prev_ready = cmd_ready;
      prev_sdr   = vji_sdr;
      post_reset = 0;
      if (reset) begin
         m_valid = 1; m_busy = 0; m_rsp = 0; post_reset = 1; tdo_pend = 0;
         m_ir_in = '0; m_rsp_dr_exp = '0; m_rsp_ir_exp = '0; m_rises = 0;
      end else if (m_valid) begin
         m_rsp = 0;
         if (m_busy) begin
            if ((m_k + 1) % PER == 0) begin
               r = (m_k + 1) / PER;
               m_rises = r;
               if (r >= 2 && r <= DRW + 2) check("tdi_at_rise", vji_tdi, m_cmd_dr[(r < 3) ? 0 : r - 3]);
               if (r == 2) m_ir_exp = cdr_val;
               if (r >= 3 && r <= DRW + 2) m_exp_dr[r - 3] = vji_tdo;
               tdo_next = loopback ? vji_tdi : 1'($urandom_range(0, 1));
               tdo_pend = 1;
               if (r == NRISE) begin
                  m_busy = 0; m_rsp = 1;
                  m_rsp_dr_exp = m_exp_dr;
                  m_rsp_ir_exp = m_ir_exp;
               end
            end
            m_k++;
         end else if (cmd_valid) begin
            m_busy = 1; m_k = 0; m_lat = 0; m_rises = 0;
            m_cmd_dr = cmd_dr; m_ir_in = cmd_ir; n_acc++;
            sdr_rises = 0;
            for (int i = 0; i < 5; i++) ind_cyc[i] = 0;
         end
      end
   end

   function automatic int sel(input int which);
      case (which)
         0:       return n_acc;
         1:       return n_rsp;
         default: return m_rises;
      endcase
   endfunction

   task automatic wait_for(input string name, input int which, input int target, input int budget);
      bit ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         if (sel(which) >= target) begin
            ok = 1;
            break;
         end
      end
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: timed out after %0d cycles, count %0d, required %0d", name, budget, sel(which), target);
      end
   endtask

   task automatic send(input logic [IRW-1:0] ir, input logic [DRW-1:0] dr);
      int target = n_acc + 1;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_ir = ir; cmd_dr = dr;
      wait_for("accept", 0, target, 20);
      #1;
      cmd_valid = 1'b0; cmd_ir = ~ir; cmd_dr = ~dr;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, required finish before %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int rsp0, acc0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);

      // Known loopback scan: TDO repeats TDI one TCK later.
      loopback = 1; cdr_val = 2'b10;
      rsp0 = n_rsp;
      send(IR_MONITOR, 38'h2A_5555_AAAA);
      wait_for("loop_rsp", 1, rsp0 + 1, 600);
      check("loop_rsp_dr", last_rsp_dr, 38'h14_AAAB_5554);
      check("loop_latency", last_latency, 393);
      check("loop_rsp_ir_out", last_rsp_ir, 2'b10);
      check("uir_cycles", last_ind_cyc[0], 8);
      check("cdr_cycles", last_ind_cyc[1], 8);
      check("sdr_cycles", last_ind_cyc[2], 304);
      check("udr_cycles", last_ind_cyc[3], 8);
      check("rti_cycles", last_ind_cyc[4], 64);
      check("sdr_rises", last_sdr_rises, 38);
      check("ir_in_held", vji_ir_in, IR_MONITOR);

      // Random scans with random TDO bits and status IR.
      loopback = 0;
      for (int i = 0; i < 5; i++) begin
         cdr_val = 2'($urandom);
         rsp0 = n_rsp;
         send(2'($urandom), DRW'({$urandom, $urandom}));
         wait_for("rand_rsp", 1, rsp0 + 1, 600);
      end

      // cmd_valid held high across three back-to-back commands.
      acc0 = n_acc; rsp0 = n_rsp;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_ir = IR_BREAK; cmd_dr = DRW'({$urandom, $urandom});
      for (int j = 1; j <= 3; j++) begin
         wait_for("b2b_accept", 0, acc0 + j, 600);
         #1;
         cmd_ir = 2'($urandom); cmd_dr = DRW'({$urandom, $urandom});
         if (j == 3) cmd_valid = 1'b0;
      end
      wait_for("b2b_rsp", 1, rsp0 + 3, 600);
      repeat (20) @(posedge clk);
      check("b2b_accepts", n_acc - acc0, 3);
      check("b2b_responses", n_rsp - rsp0, 3);

      // Reset while shifting SDR bit 20: abort, no response.
      cdr_val = IR_TRACEMEM;
      send(IR_TRACECTRL, DRW'({$urandom, $urandom}));
      wait_for("reach_sdr20", 2, 22, 400);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      rsp0 = n_rsp;
      repeat (450) @(posedge clk);
      check("abort_no_rsp", n_rsp - rsp0, 0);

      // Recovery scan after the abort.
      rsp0 = n_rsp;
      send(IR_TRACEMEM, DRW'({$urandom, $urandom}));
      wait_for("recover_rsp", 1, rsp0 + 1, 600);
      check("recover_latency", last_latency, NRISE * PER + 1);

      repeat (5) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
